// File: rtl/xalu_if.sv
// Bus between the E stage and the multiply/divide unit.
// Carries the issued op, operands, status and the HI/LO view.
interface xalu_if;
    logic        en;
    logic [3:0]  op;
    logic [31:0] A;
    logic [31:0] B;
    logic        start;
    logic        busy;
    logic [31:0] out;
    logic [31:0] HI;
    logic [31:0] LO;

    modport master (
        output en, op, A, B,
        input  start, busy, out, HI, LO
    );

    modport slave (
        input  en, op, A, B,
        output start, busy, out, HI, LO
    );
endinterface

// File: rtl/xalu.sv
// Multiply/divide unit for the E stage: owns HI/LO and
// models multi-cycle latency with a down-counting busy timer.
module xalu #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic  clk,
    input  logic  reset,
    xalu_if.slave bus
);
    localparam int MAXC = (MULT_CYCLES > DIV_CYCLES) ?
                          MULT_CYCLES : DIV_CYCLES;
    localparam int CW   = $clog2(MAXC + 1);

    localparam logic [3:0] OP_MULT  = 4'd1;
    localparam logic [3:0] OP_MULTU = 4'd2;
    localparam logic [3:0] OP_DIV   = 4'd3;
    localparam logic [3:0] OP_DIVU  = 4'd4;
    localparam logic [3:0] OP_MADD  = 4'd5;
    localparam logic [3:0] OP_MSUB  = 4'd6;
    localparam logic [3:0] OP_MTHI  = 4'd7;
    localparam logic [3:0] OP_MTLO  = 4'd8;
    localparam logic [3:0] OP_MFHI  = 4'd9;
    localparam logic [3:0] OP_MFLO  = 4'd10;

    logic [31:0]   hi_q;
    logic [31:0]   lo_q;
    logic          busy_q;
    logic [CW-1:0] cnt;
    logic [3:0]    op_q;
    logic [31:0]   a_q;
    logic [31:0]   b_q;

    logic          start;
    logic          is_mul;
    logic          is_div;
    logic [63:0]   prod_s;
    logic [63:0]   prod_u;
    logic [63:0]   acc;
    logic [31:0]   sq;
    logic [31:0]   sr;
    logic [31:0]   uq;
    logic [31:0]   ur;

    assign is_mul = (bus.op == OP_MULT) || (bus.op == OP_MULTU) ||
                    (bus.op == OP_MADD) || (bus.op == OP_MSUB);
    assign is_div = (bus.op == OP_DIV) || (bus.op == OP_DIVU);
    assign start  = bus.en && (is_mul || is_div) && !busy_q;

    // Sign extension then a 64-bit product gives the signed result mod 2^64.
    assign prod_s = {{32{a_q[31]}}, a_q} * {{32{b_q[31]}}, b_q};
    assign prod_u = {32'd0, a_q} * {32'd0, b_q};
    assign acc    = {hi_q, lo_q};

    // Dividers work on magnitudes; a zero divisor is steered to 1 to
    // keep X out of the datapath, its result is discarded at commit.
    always_comb begin
        logic [31:0] ma;
        logic [31:0] mb;
        logic [31:0] qs;
        logic [31:0] rs;
        logic [31:0] db;
        ma = a_q[31] ? (32'd0 - a_q) : a_q;
        mb = b_q[31] ? (32'd0 - b_q) : b_q;
        if (mb == 32'd0) mb = 32'd1;
        qs = ma / mb;
        rs = ma % mb;
        sq = (a_q[31] ^ b_q[31]) ? (32'd0 - qs) : qs;
        sr = a_q[31] ? (32'd0 - rs) : rs;
        db = (b_q == 32'd0) ? 32'd1 : b_q;
        uq = a_q / db;
        ur = a_q % db;
    end

    // Issue, countdown, commit and the single-cycle HI/LO moves.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hi_q   <= '0;
            lo_q   <= '0;
            busy_q <= 1'b0;
            cnt    <= '0;
            op_q   <= '0;
            a_q    <= '0;
            b_q    <= '0;
        end else if (busy_q) begin
            cnt <= cnt - CW'(1);
            if (cnt == CW'(1)) begin
                busy_q <= 1'b0;
                unique case (op_q)
                    OP_MULT:  {hi_q, lo_q} <= prod_s;
                    OP_MULTU: {hi_q, lo_q} <= prod_u;
                    OP_MADD:  {hi_q, lo_q} <= acc + prod_s;
                    OP_MSUB:  {hi_q, lo_q} <= acc - prod_s;
                    OP_DIV: begin
                        if (b_q != 32'd0) begin
                            hi_q <= sr;
                            lo_q <= sq;
                        end
                    end
                    OP_DIVU: begin
                        if (b_q != 32'd0) begin
                            hi_q <= ur;
                            lo_q <= uq;
                        end
                    end
                    default: ;
                endcase
            end
        end else if (start) begin
            busy_q <= 1'b1;
            op_q   <= bus.op;
            a_q    <= bus.A;
            b_q    <= bus.B;
            cnt    <= is_div ? CW'(DIV_CYCLES) : CW'(MULT_CYCLES);
        end else if (bus.en) begin
            if (bus.op == OP_MTHI) hi_q <= bus.A;
            if (bus.op == OP_MTLO) lo_q <= bus.A;
        end
    end

    // Move-from reads are combinational and zero when not selected.
    always_comb begin
        bus.out = 32'd0;
        if (bus.en && bus.op == OP_MFHI) bus.out = hi_q;
        if (bus.en && bus.op == OP_MFLO) bus.out = lo_q;
    end

    assign bus.start = start;
    assign bus.busy  = busy_q;
    assign bus.HI    = hi_q;
    assign bus.LO    = lo_q;
endmodule

// File: tb/tb_xalu.sv
// Directed bench for xalu: a vector table applied in sequence
// plus hand-written busy-window and reset sequences.
module tb_xalu;
    logic clk;
    logic reset;
    xalu_if bus();

    xalu #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int compared;
    int mismatched;

    typedef struct {
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        int          cyc;
        logic [31:0] hi;
        logic [31:0] lo;
    } vec_t;

    vec_t vt[16];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic mv(input logic [3:0] op, input logic [31:0] v);
        bus.en = 1'b1;
        bus.op = op;
        bus.A  = v;
        tick();
        bus.en = 1'b0;
        bus.op = 4'd0;
    endtask

    task automatic run_vec(input int i);
        int c;
        bus.en = 1'b1;
        bus.op = vt[i].op;
        bus.A  = vt[i].a;
        bus.B  = vt[i].b;
        #1;
        chk($sformatf("v%0d start", i), 32'(bus.start),
            32'(vt[i].cyc != 0));
        tick();
        bus.en = 1'b0;
        bus.op = 4'd0;
        c = 0;
        while (bus.busy && c < 200) begin
            c++;
            tick();
        end
        chk($sformatf("v%0d busy cycles", i), 32'(c), 32'(vt[i].cyc));
        chk($sformatf("v%0d HI", i), bus.HI, vt[i].hi);
        chk($sformatf("v%0d LO", i), bus.LO, vt[i].lo);
        bus.en = 1'b1;
        bus.op = 4'd9;
        #1;
        chk($sformatf("v%0d mfhi", i), bus.out, vt[i].hi);
        bus.op = 4'd10;
        #1;
        chk($sformatf("v%0d mflo", i), bus.out, vt[i].lo);
        bus.en = 1'b0;
        #1;
        chk($sformatf("v%0d out idle", i), bus.out, 32'd0);
    endtask

    initial begin
        int c;
        compared   = 0;
        mismatched = 0;

        //            op     A             B             cyc HI            LO
        vt[0]  = '{4'd1,  32'hFFFFFFFF, 32'h00000002, 5,  32'hFFFFFFFF, 32'hFFFFFFFE};
        vt[1]  = '{4'd2,  32'hFFFFFFFF, 32'hFFFFFFFF, 5,  32'hFFFFFFFE, 32'h00000001};
        vt[2]  = '{4'd5,  32'h00000001, 32'h00000001, 5,  32'hFFFFFFFE, 32'h00000002};
        vt[3]  = '{4'd6,  32'h00000002, 32'h00000001, 5,  32'hFFFFFFFE, 32'h00000000};
        vt[4]  = '{4'd3,  32'hFFFFFFF9, 32'h00000002, 10, 32'hFFFFFFFF, 32'hFFFFFFFD};
        vt[5]  = '{4'd4,  32'h00000007, 32'h00000002, 10, 32'h00000001, 32'h00000003};
        vt[6]  = '{4'd7,  32'h00000011, 32'h00000000, 0,  32'h00000011, 32'h00000003};
        vt[7]  = '{4'd8,  32'h00000022, 32'h00000000, 0,  32'h00000011, 32'h00000022};
        vt[8]  = '{4'd3,  32'h00000005, 32'h00000000, 10, 32'h00000011, 32'h00000022};
        vt[9]  = '{4'd3,  32'h80000000, 32'hFFFFFFFF, 10, 32'h00000000, 32'h80000000};
        vt[10] = '{4'd5,  32'h80000000, 32'h80000000, 5,  32'h40000000, 32'h80000000};
        vt[11] = '{4'd6,  32'h00000001, 32'h00000001, 5,  32'h40000000, 32'h7FFFFFFF};
        vt[12] = '{4'd0,  32'h12345678, 32'h9ABCDEF0, 0,  32'h40000000, 32'h7FFFFFFF};
        vt[13] = '{4'd7,  32'hFFFFFFFF, 32'h00000000, 0,  32'hFFFFFFFF, 32'h7FFFFFFF};
        vt[14] = '{4'd8,  32'hFFFFFFFF, 32'h00000000, 0,  32'hFFFFFFFF, 32'hFFFFFFFF};
        vt[15] = '{4'd5,  32'h00000001, 32'h00000001, 5,  32'h00000000, 32'h00000000};

        reset  = 1'b1;
        bus.en = 1'b0;
        bus.op = 4'd0;
        bus.A  = 32'd0;
        bus.B  = 32'd0;
        tick();
        tick();
        reset = 1'b0;
        tick();
        chk("reset busy", 32'(bus.busy), 32'd0);
        chk("reset HI", bus.HI, 32'd0);
        chk("reset LO", bus.LO, 32'd0);
        chk("reset out", bus.out, 32'd0);
        chk("reset start", 32'(bus.start), 32'd0);

        for (int i = 0; i < 16; i++) run_vec(i);

        // Ops presented during a DIVU busy window are ignored.
        mv(4'd7, 32'h000000AB);
        bus.en = 1'b1;
        bus.op = 4'd4;
        bus.A  = 32'd100;
        bus.B  = 32'd7;
        #1;
        chk("divu start", 32'(bus.start), 32'd1);
        tick();
        bus.en = 1'b0;
        c = 0;
        while (bus.busy && c < 200) begin
            c++;
            if (c == 1) begin
                bus.en = 1'b1;
                bus.op = 4'd9;
                #1;
                chk("mfhi in busy", bus.out, 32'h000000AB);
                bus.op = 4'd8;
                bus.A  = 32'h55;
                #1;
                chk("mtlo in busy start", 32'(bus.start), 32'd0);
            end else if (c == 2) begin
                bus.op = 4'd1;
                bus.A  = 32'd3;
                bus.B  = 32'd3;
                #1;
                chk("mult in busy start", 32'(bus.start), 32'd0);
            end else if (c == 3) begin
                bus.en = 1'b0;
                bus.op = 4'd0;
            end
            tick();
        end
        chk("divu busy cycles", 32'(c), 32'd10);
        chk("divu HI", bus.HI, 32'd2);
        chk("divu LO", bus.LO, 32'd14);

        // Reset in the middle of a MULT drops the pending result.
        mv(4'd7, 32'h00000077);
        mv(4'd8, 32'h00000066);
        bus.en = 1'b1;
        bus.op = 4'd1;
        bus.A  = 32'd3;
        bus.B  = 32'd4;
        tick();
        bus.en = 1'b0;
        bus.op = 4'd0;
        chk("mult busy c1", 32'(bus.busy), 32'd1);
        tick();
        reset = 1'b1;
        #1;
        chk("rst busy", 32'(bus.busy), 32'd0);
        chk("rst HI", bus.HI, 32'd0);
        chk("rst LO", bus.LO, 32'd0);
        tick();
        reset = 1'b0;
        repeat (6) tick();
        chk("post rst busy", 32'(bus.busy), 32'd0);
        chk("post rst HI", bus.HI, 32'd0);
        bus.en = 1'b1;
        bus.op = 4'd10;
        #1;
        chk("post rst mflo", bus.out, 32'd0);
        bus.en = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 compared, mismatched);
        $finish;
    end
endmodule
